// File: rtl/vga_pkg.sv
// Shared timing defaults and width helpers for the parametrised VGA generator.
package vga_pkg;

    // 640x480@60 timing: horizontal in pixel ticks, vertical in lines
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Sync polarity encodings: the value the sync pin takes while asserted
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to hold 0..total-1
    function automatic int axis_width(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): position counter plus visible and
// sync-window decode. Advances only when step is high.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP,
    parameter int W      = axis_width(axis_total(ACTIVE, FP, SYNC, BP))
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         vis,
    output logic         sync
);

    localparam int TOTAL      = axis_total(ACTIVE, FP, SYNC, BP);
    localparam int SYNC_START = ACTIVE + FP;
    localparam int SYNC_END   = ACTIVE + FP + SYNC;

    logic [31:0] count_32;
    logic        at_last;

    // Decode the current position; wrap only qualifies on a step
    always_comb begin
        count_32 = 32'(count);
        at_last  = (count_32 == 32'(TOTAL - 1));
        wrap     = step && at_last;
        vis      = (count_32 < 32'(ACTIVE));
        sync     = (count_32 >= 32'(SYNC_START)) && (count_32 < 32'(SYNC_END));
    end

    // Position register, wraps to 0 after the last back-porch position
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (step) begin
            count <= at_last ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_gen.sv
// Parametrised grayscale VGA timing generator. Pulls pixels from a frame
// source through single-cycle strobes and emits registered sync/pixel outputs.
module vga_gen
    import vga_pkg::*;
#(
    parameter int GRAY_BITS = 4,
    parameter int DIV_BITS  = 4,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = SYNC_ACTIVE_LOW,
    parameter bit VSYNC_POL = SYNC_ACTIVE_LOW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_BITS-1:0]  pixel_div,
    input  logic                 double_mode,
    output logic                 h_sync_out,
    output logic                 v_sync_out,
    output logic [GRAY_BITS-1:0] gray_out,
    output logic                 active_out,
    output logic                 frame_next_pixel_out,
    output logic                 frame_line_rewind_out,
    output logic                 frame_reset_out,
    input  logic [GRAY_BITS-1:0] frame_pixel_in
);

    localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = axis_width(H_TOTAL);
    localparam int VW      = axis_width(V_TOTAL);

    logic [DIV_BITS-1:0]  div_cnt;
    logic                 tick;
    logic [HW-1:0]        h_cnt;
    logic [VW-1:0]        v_cnt;
    logic                 h_wrap, h_vis, h_sync;
    logic                 v_wrap, v_vis, v_sync;
    logic                 vis;
    logic                 dbl;
    logic                 fetch;
    logic [GRAY_BITS-1:0] pix;

    // Pixel tick; >= so that lowering pixel_div below the running count
    // terminates the period on the next cycle instead of wrapping the counter
    always_comb begin
        tick = !rst && (div_cnt >= pixel_div);
    end

    // Clock divider: counts 0..pixel_div, restarting after each tick
    always_ff @(posedge clk) begin
        if (rst || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (HW)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .step   (tick),
        .count  (h_cnt),
        .wrap   (h_wrap),
        .vis    (h_vis),
        .sync   (h_sync)
    );

    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (VW)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .step   (h_wrap),
        .count  (v_cnt),
        .wrap   (v_wrap),
        .vis    (v_vis),
        .sync   (v_sync)
    );

    // Source handshake strobes; in double mode only even columns fetch and the
    // even visible lines rewind so the following odd line replays them
    always_comb begin
        vis                   = h_vis && v_vis;
        fetch                 = tick && vis && (!dbl || !h_cnt[0]);
        frame_next_pixel_out  = fetch;
        frame_line_rewind_out = tick && dbl && v_vis && !v_cnt[0]
                                && (32'(h_cnt) == 32'(H_ACTIVE - 1));
        frame_reset_out       = h_wrap && v_wrap;
    end

    // Double mode is only allowed to change on a frame boundary
    always_ff @(posedge clk) begin
        if (rst || (h_wrap && v_wrap)) begin
            dbl <= double_mode;
        end
    end

    // Registered outputs, updated once per pixel tick and held in between
    always_ff @(posedge clk) begin
        if (rst) begin
            pix        <= '0;
            gray_out   <= '0;
            active_out <= 1'b0;
            h_sync_out <= !HSYNC_POL;
            v_sync_out <= !VSYNC_POL;
        end else if (tick) begin
            if (fetch) begin
                pix <= frame_pixel_in;
            end
            gray_out   <= vis ? (fetch ? frame_pixel_in : pix) : '0;
            active_out <= vis;
            h_sync_out <= h_sync ? HSYNC_POL : !HSYNC_POL;
            v_sync_out <= v_sync ? VSYNC_POL : !VSYNC_POL;
        end
    end

endmodule

// File: tb/tb_vga_gen.sv
// Randomised bench for vga_gen on a reduced 8x4 timing, both sync polarities.
module tb_vga_gen;

    localparam int GB  = 4;
    localparam int HA  = 8;
    localparam int HFP = 2;
    localparam int HS  = 2;
    localparam int HBP = 2;
    localparam int VA  = 4;
    localparam int VFP = 1;
    localparam int VS  = 1;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HS + HBP;
    localparam int VT  = VA + VFP + VS + VBP;
    localparam int FT  = HT * VT;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    pixel_div;
    logic          double_mode;
    logic [GB-1:0] frame_pixel_in;

    logic          hs_a, vs_a, act_a, nxt_a, rew_a, frs_a;
    logic [GB-1:0] gray_a;
    logic          hs_b, vs_b, act_b, nxt_b, rew_b, frs_b;
    logic [GB-1:0] gray_b;

    always #5 clk = ~clk;

    vga_gen #(
        .GRAY_BITS(GB), .DIV_BITS(4),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .pixel_div(pixel_div), .double_mode(double_mode),
        .h_sync_out(hs_a), .v_sync_out(vs_a), .gray_out(gray_a), .active_out(act_a),
        .frame_next_pixel_out(nxt_a), .frame_line_rewind_out(rew_a),
        .frame_reset_out(frs_a), .frame_pixel_in(frame_pixel_in)
    );

    vga_gen #(
        .GRAY_BITS(GB), .DIV_BITS(4),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut_pos (
        .clk(clk), .rst(rst), .pixel_div(pixel_div), .double_mode(double_mode),
        .h_sync_out(hs_b), .v_sync_out(vs_b), .gray_out(gray_b), .active_out(act_b),
        .frame_next_pixel_out(nxt_b), .frame_line_rewind_out(rew_b),
        .frame_reset_out(frs_b), .frame_pixel_in(frame_pixel_in)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // The picture the source holds: a ramp offset by base, indexed by the
    // source pixel that (h,v) maps to in normal or doubled scan-out
    function automatic logic [GB-1:0] image(input int h, input int v, input bit d, input int base);
        int idx;
        idx = d ? (v / 2) * (HA / 2) + (h / 2) : v * HA + h;
        return GB'((idx + base) % 16);
    endfunction

    int  base;
    int  src_idx;
    int  mcnt;
    int  mp;
    bit  mdbl;
    int  h, v;
    bit  vis, tick, m_fetch, m_rew, m_frs, hs_on, vs_on;
    bit  s_fetch, s_rew, s_frs;
    bit  did_mid_rst;
    logic [GB-1:0] e_gray;
    bit  e_act, e_hs_on, e_vs_on;

    initial begin
        base           = int'($urandom_range(0, 15));
        rst            = 1'b1;
        pixel_div      = 4'd0;
        double_mode    = 1'b0;
        frame_pixel_in = '0;
        src_idx        = 0;
        mcnt           = 0;
        mp             = 0;
        mdbl           = 1'b0;
        e_gray         = '0;
        e_act          = 1'b0;
        e_hs_on        = 1'b0;
        e_vs_on        = 1'b0;
        did_mid_rst    = 1'b0;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (cyc < 3) begin
                rst = 1'b1;
            end else if (cyc < 300) begin
                rst = 1'b0;
                pixel_div = 4'd0;
            end else if (cyc < 700) begin
                rst = 1'b0;
                pixel_div = (cyc < 500) ? 4'd3 : 4'd1;
                if (cyc == 350) double_mode = 1'b1;
            end else begin
                rst = ($urandom_range(0, 599) == 0);
                if (!did_mid_rst && cyc > 1000 && mp == 2 * HT + 5) begin
                    rst = 1'b1;
                    did_mid_rst = 1'b1;
                end
                if ($urandom_range(0, 59) == 0) pixel_div = 4'($urandom_range(0, 3));
                if ($urandom_range(0, 149) == 0) double_mode = ~double_mode;
            end
            frame_pixel_in = GB'((src_idx + base) % 16);
            #1;

            check("gray", 32'(gray_a), 32'(e_gray));
            check("active", 32'(act_a), 32'(e_act));
            check("hsync", 32'(hs_a), 32'(!e_hs_on));
            check("vsync", 32'(vs_a), 32'(!e_vs_on));
            check("gray_pos", 32'(gray_b), 32'(e_gray));
            check("active_pos", 32'(act_b), 32'(e_act));
            check("hsync_pos", 32'(hs_b), 32'(e_hs_on));
            check("vsync_pos", 32'(vs_b), 32'(e_vs_on));

            h       = mp % HT;
            v       = mp / HT;
            vis     = (h < HA) && (v < VA);
            tick    = !rst && (mcnt >= int'(pixel_div));
            m_fetch = tick && vis && (!mdbl || (h % 2 == 0));
            m_rew   = tick && mdbl && (v < VA) && (v % 2 == 0) && (h == HA - 1);
            m_frs   = tick && (mp == FT - 1);
            check("next_pixel", 32'(nxt_a), 32'(m_fetch));
            check("line_rewind", 32'(rew_a), 32'(m_rew));
            check("frame_reset", 32'(frs_a), 32'(m_frs));
            check("next_pixel_pos", 32'(nxt_b), 32'(m_fetch));
            check("line_rewind_pos", 32'(rew_b), 32'(m_rew));
            check("frame_reset_pos", 32'(frs_b), 32'(m_frs));
            s_fetch = nxt_a;
            s_rew   = rew_a;
            s_frs   = frs_a;

            @(posedge clk);
            if (rst) begin
                mcnt    = 0;
                mp      = 0;
                mdbl    = double_mode;
                e_gray  = '0;
                e_act   = 1'b0;
                e_hs_on = 1'b0;
                e_vs_on = 1'b0;
                src_idx = 0;
            end else begin
                if (s_fetch) src_idx = src_idx + 1;
                if (s_rew)   src_idx = src_idx - HA / 2;
                if (s_frs)   src_idx = 0;
                if (tick) begin
                    hs_on   = (h >= HA + HFP) && (h < HA + HFP + HS);
                    vs_on   = (v >= VA + VFP) && (v < VA + VFP + VS);
                    e_gray  = vis ? image(h, v, mdbl, base) : '0;
                    e_act   = vis;
                    e_hs_on = hs_on;
                    e_vs_on = vs_on;
                    mp      = (mp + 1) % FT;
                    if (mp == 0) mdbl = double_mode;
                    mcnt    = 0;
                end else begin
                    mcnt = mcnt + 1;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_gen.md
# vga_gen

Parametrised successor to the fixed 640x480 grayscale VGA generator. Produces H/V sync and an N-bit gray pixel stream from a generic timing description, with a runtime pixel-clock divider and a frame-latched 2x pixel/line doubling mode. Sits between the frame source (pattern/renderer logic) and the output pins, pulling pixels through a single-cycle strobe interface.

## Interface

- GRAY_BITS, 4, gray depth of pixel in/out
- DIV_BITS, 4, width of pixel_div
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixel ticks
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines
- HSYNC_POL, 0 / VSYNC_POL, 0: sync active level (0 = active-low)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- pixel_div  in  DIV_BITS  pixel tick every pixel_div+1 clk
- double_mode  in  1  2x horizontal and vertical pixel repeat; latched at frame start
- h_sync_out  out  1  horizontal sync, registered
- v_sync_out  out  1  vertical sync, registered
- gray_out  out  GRAY_BITS  pixel value, 0 during blanking
- active_out  out  1  high while gray_out is a visible pixel
- frame_next_pixel_out  out  1  one-clk strobe: frame_pixel_in consumed this edge
- frame_line_rewind_out  out  1  one-clk strobe: source replays current line (double mode)
- frame_reset_out  out  1  one-clk strobe: source returns to first pixel
- frame_pixel_in  in  GRAY_BITS  current pixel from frame source

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. h in 0..H_TOTAL-1, v in 0..V_TOTAL-1.
- Divider: div_cnt counts 0..pixel_div; tick when div_cnt == pixel_div, then div_cnt <= 0. pixel_div = 0 -> tick every clk. New pixel_div value compared live; if pixel_div drops below div_cnt, tick fires next cycle (div_cnt >= pixel_div treated as terminal).
- On tick: h increments, wraps at H_TOTAL-1 to 0 and increments v; v wraps at V_TOTAL-1 to 0.
- vis = (h < H_ACTIVE) && (v < V_ACTIVE). Sync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), v likewise.
- dbl = double_mode latched when (h,v) wraps to (0,0) and at reset (sampled input).
- Fetch: frame_next_pixel_out = tick && vis && (!dbl || h[0]==0). Combinational.
- Pixel reg: on tick, if fetch, pix <= frame_pixel_in; gray_out <= vis ? (fetch ? frame_pixel_in : pix) : 0.
- frame_line_rewind_out = tick && dbl && v < V_ACTIVE && v[0]==0 && h == H_ACTIVE-1. Source rewinds H_ACTIVE/2 pixels.
- frame_reset_out = tick && h == H_TOTAL-1 && v == V_TOTAL-1.
- H_ACTIVE and V_ACTIVE must be even when double mode is used.

## Timing

- Reset: h=v=0, div_cnt=0, pix=0, gray_out=0, active_out=0, syncs at inactive level (!POL), all strobes 0, dbl=double_mode.
- First tick on the first clk after rst deasserts when pixel_div=0; otherwise after pixel_div+1 clks.
- Latency: strobe at edge of tick for (h,v); gray_out, active_out, h_sync_out, v_sync_out for that (h,v) valid from that edge, held until the next tick edge.
- Source must present next pixel by the next strobe; frame_pixel_in sampled only in strobe cycles.
- rst mid-frame: all state returns to reset values next edge; no strobe issued during rst; source must be reset alongside (frame_reset_out not asserted by rst).
- double_mode changes mid-frame take effect only after the next frame wrap.

## Structure

- Package vga_pkg: default timing constants for 640x480@60, sync-polarity constants, total/width helper functions (clog2 of totals for counter widths).
- Sub-module vga_axis_counter: one counter with parametrised ACTIVE/FP/SYNC/BP, inputs step, outputs count, wrap, vis, sync; instantiated for H (step=tick) and V (step=tick && h wrap).

## Test plan

- Small timing (H 8/2/2/2, V 4/1/1/1), pixel_div=0: h_sync low for exactly 2 clks per 14-clk line; 32 strobes per frame; frame_reset_out once every 14*7=98 clks.
- pixel_div=3: strobes spaced 4 clks; gray_out holds each value 4 clks; change pixel_div 3->1 mid-line, ticks every 2 clks from next wrap, no glitch tick.
- Source ramp 0,1,2,...: gray_out follows ramp in visible area, 0 in blanking, active_out matches.
- double_mode=1 asserted mid-frame: no effect until frame wrap; then 4 strobes per line, each value twice, frame_line_rewind_out on even visible lines only, each line pair identical.
- Sync polarity params 1/1: syncs idle low, pulse high at same positions.
- rst asserted at h=5, v=2 for 1 clk: outputs go to reset values next edge, counting restarts from (0,0).
